ps2_kbd_tx: RTL and testbench

Device-side PS/2 keyboard transmitter. It accepts scan-code bytes from a write port into an internal FIFO and serializes each byte onto ps2_clk/ps2_data as a standard 11-bit device-to-host frame. It sits on the keyboard side of the PS/2 link and drives our host-side PS/2 receiver in simulation and in loopback tests on the board.

---
 rtl/ps2_kbd_tx.sv | 178 +++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 device-side transmitter: scan-code FIFO plus 11-bit frame serializer.
// Optional parity-error injection is enabled by defining PS2_TX_PARITY_ERR_EN.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 100,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       par_err,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV + GAP_CYCLES);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_BIT  = 4'd10;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          par;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic [9:0]    shreg, shreg_n;
  logic          ps2_clk_n, ps2_data_n, done_n;

  // full is taken from the pre-pop count, so a write while full drops even if a pop coincides
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = wr && !full;
  assign head  = mem[rd_ptr];
  assign busy  = (state != IDLE);

`ifdef PS2_TX_PARITY_ERR_EN
  assign par = ~^head ^ par_err;
`else
  logic unused_par_err;
  assign unused_par_err = par_err;
  assign par = ~^head;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      ps2_clk  <= ps2_clk_n;
      ps2_data <= ps2_data_n;
      done     <= done_n;
    end
  end

  // Shift register holds {stop, parity, data}; start bit is driven directly at the pop.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    ps2_clk_n  = ps2_clk;
    ps2_data_n = ps2_data;
    done_n     = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shreg_n    = {1'b1, par, head};
          ps2_data_n = 1'b0;
          idx_n      = '0;
          cnt_n      = HALF_LOAD;
          state_n    = HIGH;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          ps2_clk_n = 1'b0;
          cnt_n     = HALF_LOAD;
          state_n   = LOW;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          ps2_clk_n = 1'b1;
          if (idx != LAST_BIT) begin
            // Data only moves with the rising ps2_clk, keeping it stable over every falling edge
            idx_n      = idx + 4'd1;
            ps2_data_n = shreg[0];
            shreg_n    = {1'b1, shreg[9:1]};
            cnt_n      = HALF_LOAD;
            state_n    = HIGH;
          end else begin
            done_n     = 1'b1;
            ps2_data_n = 1'b1;
            cnt_n      = GAP_LOAD;
            state_n    = GAP;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - scoreboard bench for ps2_kbd_tx with a receiver-model monitor.
module tb_ps2_kbd_tx;
  localparam int D     = 4;
  localparam int G     = 6;
  localparam int DEPTH = 8;
  localparam int FRAME = 22 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0;
  logic       par_err = 1'b0;
  logic       ps2_clk, ps2_data, full, empty, busy, overflow, done;

  ps2_kbd_tx #(.CLK_DIV(D), .GAP_CYCLES(G), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .wr(wr), .par_err(par_err),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .full(full), .empty(empty),
    .busy(busy), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [10:0] frame;
    bit          ok;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_fifo[$];
  bit         started = 0;
  int         start_cyc = 0;
  int         last_start_gap = 0;
  bit         ovf_m = 0;
  bit         prev_busy = 0;
  logic       prev_clk = 1'b1;
  logic       prev_data = 1'b1;
  int         falls_total = 0;
  int         frame_falls = 0;
  bit         pend_acc = 0;
  logic [7:0] pend_byte = 8'h00;

  logic [10:0] last_frame = '0;
  bit          last_ok = 0;

  // Expected frame from first principles: start 0, data LSB first, odd parity, stop 1
  function automatic exp_t make_exp(input logic [7:0] b, input bit flip);
    exp_t e;
    logic p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    p = p ^ flip;
    e.frame = {1'b1, p, b, 1'b0};
    e.ok = !flip;
    return e;
  endfunction

  function automatic bit busy_now();
    return started && ((cyc - start_cyc) < FRAME + G);
  endfunction

  task automatic cycle(input logic w, input logic [7:0] d, input logic pe);
    bit pop_exp, pop_seen, flip;
    @(negedge clk);
    pop_exp  = !prev_busy && (model_fifo.size() > 0);
    pop_seen = prev_clk && prev_data && ps2_clk && !ps2_data;
    chk("pop_timing", pop_seen, pop_exp);
    if (prev_clk && !ps2_clk) begin
      falls_total++;
      frame_falls++;
    end
    if (pop_exp) begin
`ifdef PS2_TX_PARITY_ERR_EN
      flip = par_err;
`else
      flip = 1'b0;
`endif
      if (started) last_start_gap = cyc - start_cyc;
      exp_q.push_back(make_exp(model_fifo.pop_front(), flip));
      started = 1;
      start_cyc = cyc;
      frame_falls = 0;
    end
    if (pend_acc) model_fifo.push_back(pend_byte);
    chk("empty", empty, model_fifo.size() == 0);
    chk("full", full, model_fifo.size() == DEPTH);
    chk("overflow", overflow, ovf_m);
    chk("busy", busy, busy_now());
    chk("done", done, started && (cyc - start_cyc == FRAME));
    prev_busy = busy_now();
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
    wr = w;
    din = d;
    par_err = pe;
    pend_acc = w && (model_fifo.size() < DEPTH);
    pend_byte = d;
    if (w && model_fifo.size() >= DEPTH) ovf_m = 1;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (model_fifo.size() == 0 && !prev_busy && exp_q.size() == 0 && !pend_acc) return;
      cycle(1'b0, 8'h00, 1'b0);
    end
    chk("idle_timeout", 1, 0);
  endtask

  // Host-side receiver: samples ps2_data on every falling ps2_clk
  int          nbits = 0;
  logic [10:0] rx_sh = '0;
  always @(negedge ps2_clk or posedge rst) begin
    if (rst) begin
      nbits = 0;
    end else begin
      rx_sh = {ps2_data, rx_sh[10:1]};
      nbits++;
      if (nbits == 11) begin
        exp_t e;
        bit ok;
        nbits = 0;
        ok = (rx_sh[0] == 1'b0) && (rx_sh[10] == 1'b1) && (^rx_sh[9:1] == 1'b1);
        last_frame = rx_sh;
        last_ok = ok;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_bits", rx_sh, e.frame);
          chk("rx_accept", ok, e.ok);
        end
      end
    end
  end

  initial begin
    int n0;
    bit seen;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    cycle(1'b1, 8'h1C, 1'b0);
    wait_idle(400);
    chk("t1_frame", last_frame, 11'b10000111000);
    chk("t1_ok", last_ok, 1);

    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    wait_idle(600);
    chk("t2_gap", last_start_gap, FRAME + G + 1);
    chk("t2_last", last_frame, 11'b10000111000);

    cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0);
    chk("t3_full", full, 1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("t3_ovf", overflow, 1);
    wait_idle(10 * (FRAME + G + 1) + 50);
    chk("t3_empty", empty, 1);
    chk("t3_ovf_sticky", overflow, 1);

    cycle(1'b1, 8'hA5, 1'b0);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (started && busy_now() && frame_falls == 4) seen = 1;
    end
    chk("t4_reached_fall4", seen, 1);
    #1 rst = 1'b1;
    #1;
    chk("t4_ps2_clk", ps2_clk, 1);
    chk("t4_ps2_data", ps2_data, 1);
    chk("t4_empty", empty, 1);
    chk("t4_busy", busy, 0);
    exp_q.delete();
    model_fifo.delete();
    started = 0; ovf_m = 0; prev_busy = 0; pend_acc = 0;
    prev_clk = 1'b1; prev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = falls_total;
    repeat (4 * D) cycle(1'b0, 8'h00, 1'b0);
    chk("t4_no_edges", falls_total - n0, 0);
    cycle(1'b1, 8'h00, 1'b0);
    wait_idle(400);
    chk("t4_frame00", last_frame, 11'b11000000000);

    cycle(1'b1, 8'h1C, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    wait_idle(400);
`ifdef PS2_TX_PARITY_ERR_EN
    chk("t5_parity_bit", last_frame[9], 1);
    chk("t5_rejected", last_ok, 0);
`else
    chk("t5_parity_bit", last_frame[9], 0);
    chk("t5_accepted", last_ok, 1);
`endif
    cycle(1'b1, 8'h1C, 1'b0);
    wait_idle(400);
    chk("t5_next_ok", last_ok, 1);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 29) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
    end
    wait_idle(DEPTH * (FRAME + G + 1) + 200);
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
